// File: rtl/chien_par_pkg.sv
// Shared GF(2^M) helpers for the parallel Chien search: state encoding,
// primitive polynomials, alpha powers, constant-multiplier masks, clog2.
package chien_par_pkg;

  localparam int GF_W = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ceiling log2; the number of bits needed to index v values.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  // Standard primitive polynomial per field width (x^M term included).
  function automatic logic [GF_W:0] prim_poly(input int m);
    case (m)
      3:       return 17'h0000B;
      4:       return 17'h00013;
      5:       return 17'h00025;
      6:       return 17'h00043;
      7:       return 17'h00089;
      8:       return 17'h0011D;
      9:       return 17'h00211;
      10:      return 17'h00409;
      11:      return 17'h00805;
      12:      return 17'h01053;
      13:      return 17'h0201B;
      14:      return 17'h04443;
      15:      return 17'h08003;
      16:      return 17'h1100B;
      default: return 17'h00013;
    endcase
  endfunction

  // Multiply a field element by alpha.
  function automatic logic [GF_W-1:0] xtime(input int m, input logic [GF_W-1:0] v);
    logic [GF_W:0] t;
    t = {v, 1'b0};
    if (((t >> m) & 17'd1) != 17'd0) t = t ^ prim_poly(m);
    return t[GF_W-1:0];
  endfunction

  // alpha^i as a field element.
  function automatic logic [GF_W-1:0] lpow(input int m, input int i);
    logic [GF_W-1:0] v;
    int e;
    e = i % ((1 << m) - 1);
    v = 16'd1;
    for (int k = 0; k < e; k++) v = xtime(m, v);
    return v;
  endfunction

  // Row b of the constant multiplier matrix for c: input bit i feeds
  // output bit b when bit b of c*alpha^i is set.
  function automatic logic [GF_W-1:0] mul_mask(input int m, input logic [GF_W-1:0] c,
                                               input int b);
    logic [GF_W-1:0] v;
    logic [GF_W-1:0] mk;
    v  = c;
    mk = 16'd0;
    for (int i = 0; i < GF_W; i++) begin
      if (i < m) begin
        mk = mk | (GF_W'((v >> b) & 16'd1) << i);
        v  = xtime(m, v);
      end
    end
    return mk;
  endfunction

endpackage

// File: rtl/chien_par_if.sv
// Control/status bundle between the key-equation stage, the Chien search
// and the correction stage.
interface chien_par_if
  import chien_par_pkg::*;
#(
  parameter int M = 4,
  parameter int T = 3,
  parameter int P = 1,
  parameter int N = (1 << M) - 1
);
  localparam int DW   = clog2(T + 1);
  localparam int PW   = clog2(N + 1);
  localparam int CNTW = clog2(T + 2);

  logic                 start;
  logic                 ce;
  logic [M*(T+1)-1:0]   sigma;
  logic [DW-1:0]        deg;
  logic                 busy;
  logic                 err_valid;
  logic [P-1:0]         err;
  logic [PW-1:0]        err_pos;
  logic                 done;
  logic                 fail;
  logic [CNTW-1:0]      err_count;

  modport master (
    output start, ce, sigma, deg,
    input  busy, err_valid, err, err_pos, done, fail, err_count
  );

  modport slave (
    input  start, ce, sigma, deg,
    output busy, err_valid, err, err_pos, done, fail, err_count
  );
endinterface

// File: rtl/chien_par_term.sv
// One locator term r_j = sigma_j * alpha^(j*c*P) with its step multiplier
// and the P lane products r_j * alpha^(j*(p+1)); all constant XOR networks.
module chien_term
  import chien_par_pkg::*;
#(
  parameter int M = 4,
  parameter int J = 1,
  parameter int P = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [M-1:0]   coef,
  output logic [P*M-1:0] lanes
);
  localparam logic [GF_W-1:0] STEP_C = lpow(M, J * P);

  logic [M-1:0] term_r;
  logic [M-1:0] next_s;

  for (genvar b = 0; b < M; b++) begin : g_step
    localparam logic [GF_W-1:0] MK = mul_mask(M, STEP_C, b);
    assign next_s[b] = ^(term_r & MK[M-1:0]);
  end

  for (genvar p = 0; p < P; p++) begin : g_lane
    for (genvar b = 0; b < M; b++) begin : g_bit
      localparam logic [GF_W-1:0] MKL = mul_mask(M, lpow(M, J * (p + 1)), b);
      assign lanes[p*M+b] = ^(term_r & MKL[M-1:0]);
    end
  end

  // Term register: load the coefficient at start, advance by alpha^(J*P) per beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      term_r <= '0;
    end else if (load) begin
      term_r <= coef;
    end else if (step) begin
      term_r <= next_s;
    end else begin
      term_r <= term_r;
    end
  end
endmodule

// File: rtl/chien_par.sv
// P-lane parallel Chien search: evaluates sigma(alpha^k) for k = 1..N,
// P positions per beat, flags roots, counts them and reports decode failure.
module chien_par
  import chien_par_pkg::*;
#(
  parameter int M = 4,
  parameter int T = 3,
  parameter int P = 1,
  parameter int N = (1 << M) - 1
) (
  input  logic       clk,
  input  logic       reset,
  chien_par_if.slave bus
);
  localparam int DW   = clog2(T + 1);
  localparam int PW   = clog2(N + 1);
  localparam int CNTW = clog2(T + 2);
  localparam int C    = (N + P - 1) / P;

  state_t          state_r, state_s;
  logic [M-1:0]    sig0_r;
  logic [DW-1:0]   deg_r;
  logic            zero_r;
  logic [PW-1:0]   beat_r;
  logic [CNTW-1:0] cnt_r, cnt_s;
  logic            err_valid_r, done_r, fail_r;
  logic [P-1:0]    err_r, flag_s;
  logic [PW-1:0]   err_pos_r;
  logic            load_s, step_s, last_s;
  logic [P*M-1:0]  lane_prod_s [1:T];

  assign load_s = (state_r == IDLE) && bus.start;
  assign step_s = (state_r == RUN) && bus.ce;
  assign last_s = (beat_r == PW'(C - 1));

  for (genvar j = 1; j <= T; j++) begin : g_term
    chien_term #(.M(M), .J(j), .P(P)) u_term (
      .clk   (clk),
      .reset (reset),
      .load  (load_s),
      .step  (step_s),
      .coef  (bus.sigma[j*M +: M]),
      .lanes (lane_prod_s[j])
    );
  end

  // Lane XOR trees; positions beyond N on the final partial beat are masked.
  always_comb begin
    logic [M-1:0] acc;
    int           k;
    flag_s = '0;
    acc    = '0;
    k      = 0;
    for (int p = 0; p < P; p++) begin
      acc = sig0_r;
      for (int j = 1; j <= T; j++) acc = acc ^ lane_prod_s[j][p*M +: M];
      k = int'(beat_r) * P + p + 1;
      flag_s[p] = (acc == '0) && (k <= N);
    end
  end

  // Running root count including this beat, saturating at T+1.
  always_comb begin
    int pop;
    int total;
    pop = 0;
    for (int p = 0; p < P; p++) pop = pop + int'(flag_s[p]);
    total = int'(cnt_r) + pop;
    if (total > T + 1) begin
      cnt_s = CNTW'(T + 1);
    end else begin
      cnt_s = CNTW'(total);
    end
  end

  // Next state: leave IDLE on start, return after the last qualified beat.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = RUN;
        else           state_s = IDLE;
      end
      RUN: begin
        if (step_s && last_s) state_s = IDLE;
        else                  state_s = RUN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Capture, beat counter, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig0_r      <= '0;
      deg_r       <= '0;
      zero_r      <= 1'b0;
      beat_r      <= '0;
      cnt_r       <= '0;
      err_valid_r <= 1'b0;
      done_r      <= 1'b0;
      fail_r      <= 1'b0;
      err_r       <= '0;
      err_pos_r   <= '0;
    end else begin
      err_valid_r <= 1'b0;
      done_r      <= 1'b0;
      if (load_s) begin
        sig0_r <= bus.sigma[M-1:0];
        deg_r  <= bus.deg;
        zero_r <= (bus.sigma == '0);
        beat_r <= '0;
        cnt_r  <= '0;
      end else if (step_s) begin
        err_r       <= flag_s;
        err_pos_r   <= PW'(int'(beat_r) * P);
        err_valid_r <= 1'b1;
        beat_r      <= beat_r + PW'(1);
        cnt_r       <= cnt_s;
        if (last_s) begin
          done_r <= 1'b1;
          fail_r <= (CNTW'(deg_r) != cnt_s) || zero_r;
        end
      end
    end
  end

  assign bus.busy      = (state_r == RUN);
  assign bus.err_valid = err_valid_r;
  assign bus.err       = err_r;
  assign bus.err_pos   = err_pos_r;
  assign bus.done      = done_r;
  assign bus.fail      = fail_r;
  assign bus.err_count = cnt_r;
endmodule

// File: tb/tb_chien_par.sv
// Randomized bench for chien_par (M=4, T=3, N=15) with P=1 and P=4 instances,
// checked against a log/antilog polynomial-evaluation model.
module tb_chien_par;
  localparam int M = 4;
  localparam int T = 3;
  localparam int N = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chien_par_if #(.M(M), .T(T), .P(1), .N(N)) bus1 ();
  chien_par_if #(.M(M), .T(T), .P(4), .N(N)) bus4 ();

  chien_par #(.M(M), .T(T), .P(1), .N(N)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  chien_par #(.M(M), .T(T), .P(4), .N(N)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  logic        sel;
  logic        o_busy, o_valid, o_done, o_fail;
  logic [3:0]  o_err, o_pos;
  logic [2:0]  o_cnt;

  assign o_busy  = sel ? bus4.busy      : bus1.busy;
  assign o_valid = sel ? bus4.err_valid : bus1.err_valid;
  assign o_done  = sel ? bus4.done      : bus1.done;
  assign o_fail  = sel ? bus4.fail      : bus1.fail;
  assign o_err   = sel ? bus4.err       : {3'b000, bus1.err};
  assign o_pos   = sel ? bus4.err_pos   : bus1.err_pos;
  assign o_cnt   = sel ? bus4.err_count : bus1.err_count;

  int checks = 0;
  int errors = 0;
  int gexp [0:14];
  int glog [0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 15];
  endfunction

  function automatic int peval(input logic [15:0] sg, input int x);
    int v;
    v = int'(sg[15:12]);
    for (int j = 2; j >= 0; j--) v = gmul(v, x) ^ int'(sg[j*4 +: 4]);
    return v;
  endfunction

  // Locator polynomial with roots at alpha^k for each listed k.
  function automatic logic [15:0] from_roots(input int nr, input int k0, input int k1,
                                             input int k2);
    int c [0:3];
    int nc [0:3];
    int ks [0:2];
    logic [15:0] r;
    ks[0] = k0; ks[1] = k1; ks[2] = k2;
    c[0] = 1; c[1] = 0; c[2] = 0; c[3] = 0;
    for (int i = 0; i < nr; i++) begin
      nc[0] = c[0];
      for (int j = 1; j < 4; j++) nc[j] = c[j] ^ gmul(gexp[(15 - ks[i]) % 15], c[j-1]);
      c = nc;
    end
    r = 16'h0000;
    for (int j = 0; j < 4; j++) r[j*4 +: 4] = 4'(c[j]);
    return r;
  endfunction

  task automatic set_start(input logic v);
    if (sel) bus4.start = v;
    else     bus1.start = v;
  endtask

  task automatic drive_common(input logic [15:0] sg, input int dg, input logic cev);
    bus1.sigma = sg; bus4.sigma = sg;
    bus1.deg = 2'(dg); bus4.deg = 2'(dg);
    bus1.ce = cev; bus4.ce = cev;
  endtask

  // One full search; called and returning at a negedge.
  task automatic run_search(input logic s, input logic [15:0] sg, input int dg,
                            input bit stall, input bit poke);
    int  pp, cc, b, cyc, cnt, k;
    bit  root [1:15];
    bit  expfail;
    logic cev;
    logic [3:0] ew;
    pp = s ? 4 : 1;
    cc = (N + pp - 1) / pp;
    cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      root[i] = (peval(sg, gexp[i % 15]) == 0);
      if (root[i]) cnt++;
    end
    if (cnt > T + 1) cnt = T + 1;
    expfail = (cnt != dg) || (sg == 16'h0000);
    sel = s;
    drive_common(sg, dg, 1'b1);
    set_start(1'b1);
    @(posedge clk); #1;
    check("busy_load", o_busy, 1);
    @(negedge clk);
    set_start(1'b0);
    b = 0; cyc = 0;
    while (b < cc && cyc < 200) begin
      cev = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      drive_common(sg, dg, cev);
      if (poke) set_start((b == cc - 1) ? 1'b1 : 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      cyc++;
      if (cev) begin
        ew = 4'b0000;
        for (int p = 0; p < pp; p++) begin
          k = b * pp + p + 1;
          if (k <= N && root[k]) ew[p] = 1'b1;
        end
        check("valid", o_valid, 1);
        check("err_pos", o_pos, b * pp);
        check("err", o_err, ew);
        check("done", o_done, (b == cc - 1) ? 1 : 0);
        if (b == cc - 1) begin
          check("err_count", o_cnt, cnt);
          check("fail", o_fail, expfail);
        end
        b++;
      end else begin
        check("valid_stall", o_valid, 0);
        check("done_stall", o_done, 0);
      end
      @(negedge clk);
    end
    if (b < cc) check("timeout", b, cc);
    set_start(1'b0);
    check("busy_after_done", o_busy, 0);
  endtask

  task automatic reset_midrun(input logic [15:0] sg);
    sel = 1'b0;
    drive_common(sg, 1, 1'b1);
    bus1.start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("pre_reset_pos", o_pos, i);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_done", o_done, 0);
    check("rst_count", o_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_done", o_done, 0);
    check("post_rst_busy", o_busy, 0);
    @(negedge clk);
  endtask

  initial begin
    int v;
    int nr, k0, k1, k2, dg;
    logic [15:0] sg;
    v = 1;
    for (int i = 0; i < 15; i++) begin
      gexp[i] = v;
      glog[v] = i;
      v = v << 1;
      if ((v & 16) != 0) v = v ^ 19;
    end
    glog[0] = 0;
    sel = 1'b0;
    reset = 1'b1;
    bus1.start = 1'b0; bus4.start = 1'b0;
    drive_common(16'h0000, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("reset_busy", o_busy, 0);
      check("reset_valid", o_valid, 0);
      check("reset_done", o_done, 0);
      check("reset_fail", o_fail, 0);
      check("reset_err", o_err, 0);
      check("reset_pos", o_pos, 0);
      check("reset_count", o_cnt, 0);
    end
    @(negedge clk);
    reset = 1'b0;

    run_search(1'b0, 16'h0001, 0, 1'b0, 1'b0);
    run_search(1'b0, 16'h0081, 1, 1'b0, 1'b0);
    run_search(1'b1, 16'h0081, 1, 1'b0, 1'b0);
    run_search(1'b1, 16'h0B21, 3, 1'b1, 1'b1);
    run_search(1'b1, 16'h0B21, 2, 1'b0, 1'b0);
    run_search(1'b0, 16'h0000, 0, 1'b0, 1'b0);
    run_search(1'b1, 16'h0000, 0, 1'b1, 1'b0);
    reset_midrun(16'h0081);
    run_search(1'b0, 16'h0081, 1, 1'b0, 1'b0);

    for (int it = 0; it < 12; it++) begin
      nr = $urandom_range(0, 3);
      k0 = $urandom_range(1, 15);
      k1 = (k0 % 15) + $urandom_range(1, 6);
      if (k1 > 15) k1 = k1 - 15;
      k2 = (k1 % 15) + $urandom_range(1, 6);
      if (k2 > 15) k2 = k2 - 15;
      if (k2 == k0) k2 = (k2 % 15) + 1;
      if (k2 == k1) k2 = (k2 % 15) + 1;
      if (k2 == k0) k2 = (k2 % 15) + 1;
      sg = from_roots(nr, k0, k1, k2);
      if ($urandom_range(0, 4) == 0) sg = 16'($urandom_range(0, 65535));
      dg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : nr;
      run_search(1'($urandom_range(0, 1)), sg, dg, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/chien_par.md
Name: chien_par

Overview:
- P-lane parallel Chien search for binary BCH decoders over GF(2^M).
- Takes the full error-locator polynomial sigma(x) = sigma0 + sigma1·x + … + sigmaT·x^T from the Berlekamp/key-equation stage.
- Evaluates sigma(alpha^k) for P consecutive k per cycle, k = 1..N, and streams per-lane error flags to the correction stage.
- New over the single-lane search: start/busy/done framing, stall via ce, masking of the last partial beat, root counting, and a decode-failure flag when the root count differs from the locator degree.

Parameters:
- M, 4, field width; GF(2^M) with the codebase's standard primitive polynomial.
- T, 3, correction capability; number of locator coefficients above sigma0.
- P, 1, positions evaluated per cycle (1..N).
- N, 2^M-1, codeword length; shortened codes use N < 2^M-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  load sigma/deg and begin a search; honoured only in IDLE.
- ce  in  1  advance enable; low in RUN freezes all state.
- sigma  in  M*(T+1)  coefficient j at [j*M +: M], sigma0 at bits [M-1:0].
- deg  in  clog2(T+1)  locator degree reported by the key-equation stage.
- busy  out  1  high in RUN.
- err_valid  out  1  err/err_pos are valid this cycle.
- err  out  P  lane p high: sigma(alpha^(err_pos+p+1)) == 0.
- err_pos  out  clog2(N+1)  k-1 of lane 0 for the current beat (c*P).
- done  out  1  one-cycle pulse coincident with the last valid beat.
- fail  out  1  valid with done: root count != deg, or sigma all-zero.
- err_count  out  clog2(T+2)  roots found; saturates at T+1; valid with done.

Behaviour:
- Reset values: state IDLE; busy, err_valid, err, err_pos, done, fail and err_count all 0; coefficient registers 0.
- Beats: C = ceil(N/P); a beat counter runs c = 0..C-1.
- Each term register r_j (j = 1..T) holds sigma_j·alpha^(j·c·P). Lane p sum is sigma0 ^ XOR over j of r_j·alpha^(j·(p+1)). Each step applies r_j <= r_j·alpha^(j·P). All multipliers are constant GF multipliers (pure XOR networks).
- IDLE: start=1 at edge e captures sigma and deg, loads r_j = sigma_j, clears c and err_count, and moves to RUN. busy=1 from edge e. start=0 means no change.
- RUN, ce=1, at each edge:
  - Register err lanes, err_pos = c·P and err_valid=1.
  - Update r_j and increment c.
  - Add the popcount of unmasked flags to err_count (saturating).
- RUN, ce=0: r_j, c, err_count and state hold; err_valid=0 and err holds its last value.
- Latency: the first valid beat appears at edge e+1 when ce is held high. Beat c appears at the (c+1)-th ce-qualified edge after load.
- Last beat (c = C-1):
  - Lanes with c·P+p+1 > N are forced to 0 and excluded from the count.
  - done=1, and fail/err_count are registered from the final count, which includes this beat.
  - State returns to IDLE on the same edge, so busy=0 on the following cycle.
- fail=1 if final count != deg, or if sigma1..sigmaT and sigma0 are all zero (every position a root).
- start in RUN is ignored, and so is a start coincident with the done edge. A new start is accepted from the first IDLE cycle after done.
- Back-to-back searches have a minimum one-cycle gap between done and the next first beat: start in the IDLE cycle, first beat on the next edge.
- reset overrides everything, including mid-RUN: return to IDLE, clear all outputs, no done pulse.
- err_valid, done, fail, err_count and err are registered (no combinational paths from inputs).

Decomposition:
- Shared package/header: lpow(M,i), the GF constant-multiplier matrix function (bit_pos/term mask generator), and clog2.
- Sub-module chien_term #(M, J, P): one r_j register with load/step, plus its P lane-product outputs. Instantiate T of them via generate.
- Top level holds the lane XOR trees, masking, popcount/accumulator, beat counter and FSM.

Test Plan:
- M=4,T=3,P=1, sigma0=1 and others 0, deg=0, start, ce=1: 15 beats all err=0; done on beat 14 (err_pos=14); err_count=0; fail=0.
- Same config, sigma0=1, sigma1=alpha^3, deg=1: err=1 only at err_pos=11 (k=12); done; err_count=1; fail=0.
- P=4 with the same sigma: C=4 beats; only beat err_pos=8 has err=4'b1000. Lane 3 of beat 12 (k=16) is masked. done on beat 3; err_count=1.
- P=4, sigma=(1+alpha^2x)(1+alpha^5x), deg=3: flags at k=13 and k=10; err_count=2; fail=1.
- Stall plus mid-run start: ce toggled 1,0,0,1 over load+3 cycles → no err_valid while ce=0, beat sequence unchanged. A start pulse during RUN has no effect; a start in IDLE after done restarts from c=0.
- Reset asserted at beat 2 of a P=1 search → next cycle busy=0, err_valid=0, no done. A fresh start then produces the full 15-beat sequence.
